meas_hold_filter: RTL and testbench

//  Conditioning stage directly upstream of the 8-digit scan display.

---
 rtl/meas_hold_filter_pkg.sv | 24 ++
 rtl/meas_avg_accum.sv | 71 +++++++
 rtl/meas_hold_filter.sv | 165 ++++++++++++++++
 tb/tb_meas_hold_filter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_hold_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : meas_hold_filter_pkg
//  Purpose : Constants shared by the display conditioning stage and by the
//            measurement and display tops that instantiate it.
//  Contents: PHAS_MAX       largest phase value the display may show
//            *_DEF          default averaging / refresh / timeout settings
//            clamp_phas()   limits a raw phase result to 0..PHAS_MAX
//  Revision: 1.0  initial release
// ============================================================================
package meas_hold_filter_pkg;

  localparam logic [11:0] PHAS_MAX = 12'd999;

  localparam int AVG_LOG2_DEF   = 2;
  localparam int REFRESH_MS_DEF = 500;
  localparam int TIMEOUT_MS_DEF = 2000;

  function automatic logic [11:0] clamp_phas(input logic [11:0] p);
    return (p > PHAS_MAX) ? PHAS_MAX : p;
  endfunction

endpackage : meas_hold_filter_pkg
`default_nettype wire

// File: rtl/meas_avg_accum.sv
`default_nettype none
// ============================================================================
//  Module  : meas_avg_accum
//  Purpose : Block averager. Sums 2**AVG_LOG2 samples in a widened
//            accumulator and presents the truncated mean in the same cycle
//            as the sample that completes the block.
//  Ports   : clk_1khz  in   clock, posedge
//            rst_n     in   asynchronous active-low reset
//            clear     in   discard the partial block
//            add       in   accept data this cycle
//            data      in   W-bit sample
//            done      out  this add completes a block (combinational)
//            avg       out  mean of the block, valid while done=1
//  Revision: 1.0  initial release
// ============================================================================
module meas_avg_accum
  import meas_hold_filter_pkg::*;
#(
  parameter int W        = 16,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic         clk_1khz,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         add,
  input  logic [W-1:0] data,
  output logic         done,
  output logic [W-1:0] avg
);

  localparam int AW = W + AVG_LOG2;

  logic [AW-1:0]       acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [AW-1:0]       sum;
  logic                last;

  always_comb begin
    sum   = acc_q + {{AVG_LOG2{1'b0}}, data};
    // Sample count wraps naturally: all-ones means this add is the last one.
    last  = &cnt_q;
    done  = add & ~clear & last;
    avg   = sum[AW-1:AVG_LOG2];
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + {{(AVG_LOG2-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule : meas_avg_accum
`default_nettype wire

// File: rtl/meas_hold_filter.sv
`default_nettype none
// ============================================================================
//  Module  : meas_hold_filter
//  Purpose : Conditions raw frequency/phase results for the scan display:
//            block averaging, fixed-rate refresh, and forced zero + stale
//            flag when the measurement core goes quiet.
//  Ports   : clk_1khz   in   scan clock, posedge
//            rst_n      in   asynchronous active-low reset
//            raw_valid  in   one-cycle pulse, raw_fre/raw_phas valid
//            raw_fre    in   16-bit raw frequency, unsigned
//            raw_phas   in   12-bit raw phase, clamped to 0..999 here
//            fre        out  held frequency
//            phas       out  held phase, 0..999
//            upd        out  one-cycle pulse when fre/phas take a new source
//            stale      out  no fresh data, outputs forced to 0
//  Revision: 1.0  initial release
// ============================================================================
module meas_hold_filter
  import meas_hold_filter_pkg::*;
#(
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int REFRESH_MS = REFRESH_MS_DEF,
  parameter int TIMEOUT_MS = TIMEOUT_MS_DEF
) (
  input  logic        clk_1khz,
  input  logic        rst_n,
  input  logic        raw_valid,
  input  logic [15:0] raw_fre,
  input  logic [11:0] raw_phas,
  output logic [15:0] fre,
  output logic [11:0] phas,
  output logic        upd,
  output logic        stale
);

  localparam int RW = (REFRESH_MS > 1) ? $clog2(REFRESH_MS) : 1;
  localparam int IW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_MS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_MS - 1);

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [15:0]   pend_f_q, pend_f_d;
  logic [11:0]   pend_p_q, pend_p_d;
  logic          pend_vld_q, pend_vld_d;
  logic          part_q, part_d;
  logic [15:0]   fre_q, fre_d;
  logic [11:0]   phas_q, phas_d;
  logic          upd_q, upd_d;
  logic          stale_q, stale_d;

  logic [11:0]   phas_c;
  logic          tick;
  logic          timeout;
  logic          done_f, done_p, blk_done;
  logic [15:0]   avg_f;
  logic [11:0]   avg_p;

  assign phas_c = clamp_phas(raw_phas);

  // Both averagers see identical strobes, so their done pulses coincide.
  meas_avg_accum #(.W(16), .AVG_LOG2(AVG_LOG2)) u_avg_fre (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .clear    (timeout),
    .add      (raw_valid),
    .data     (raw_fre),
    .done     (done_f),
    .avg      (avg_f)
  );

  meas_avg_accum #(.W(12), .AVG_LOG2(AVG_LOG2)) u_avg_phas (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .clear    (timeout),
    .add      (raw_valid),
    .data     (phas_c),
    .done     (done_p),
    .avg      (avg_p)
  );

  assign blk_done = done_f & done_p;

  always_comb begin
    tick    = (ref_cnt_q == REF_LAST);
    // part_q mirrors "partial block in progress" so a half-filled block
    // still arms the timeout. Once everything is clear and stale, nothing
    // re-arms it without a new raw_valid, so the event cannot repeat.
    timeout = ~raw_valid && (idle_q == IDLE_LAST) &&
              (~stale_q || pend_vld_q || part_q);

    ref_cnt_d  = tick ? '0 : ref_cnt_q + RW'(1);
    idle_d     = raw_valid ? '0 :
                 (idle_q == IDLE_LAST) ? idle_q : idle_q + IW'(1);

    pend_f_d   = pend_f_q;
    pend_p_d   = pend_p_q;
    pend_vld_d = pend_vld_q;
    part_d     = part_q;
    fre_d      = fre_q;
    phas_d     = phas_q;
    stale_d    = stale_q;
    upd_d      = 1'b0;

    if (timeout) begin
      fre_d      = '0;
      phas_d     = '0;
      stale_d    = 1'b1;
      upd_d      = ~stale_q;
      pend_vld_d = 1'b0;
      part_d     = 1'b0;
    end else begin
      if (tick && pend_vld_q) begin
        fre_d      = pend_f_q;
        phas_d     = pend_p_q;
        stale_d    = 1'b0;
        upd_d      = 1'b1;
        pend_vld_d = 1'b0;
      end
      // Evaluated after the tick so a block finishing on the tick cycle
      // is parked in pend for the next refresh.
      if (raw_valid) begin
        part_d = ~blk_done;
        if (blk_done) begin
          pend_f_d   = avg_f;
          pend_p_d   = avg_p;
          pend_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q  <= '0;
      idle_q     <= '0;
      pend_f_q   <= '0;
      pend_p_q   <= '0;
      pend_vld_q <= 1'b0;
      part_q     <= 1'b0;
      fre_q      <= '0;
      phas_q     <= '0;
      upd_q      <= 1'b0;
      stale_q    <= 1'b1;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      idle_q     <= idle_d;
      pend_f_q   <= pend_f_d;
      pend_p_q   <= pend_p_d;
      pend_vld_q <= pend_vld_d;
      part_q     <= part_d;
      fre_q      <= fre_d;
      phas_q     <= phas_d;
      upd_q      <= upd_d;
      stale_q    <= stale_d;
    end
  end

  assign fre   = fre_q;
  assign phas  = phas_q;
  assign upd   = upd_q;
  assign stale = stale_q;

endmodule : meas_hold_filter
`default_nettype wire

// File: tb/tb_meas_hold_filter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_meas_hold_filter
//  Purpose : Self-checking bench for meas_hold_filter with a sample-list
//            reference model and per-scenario checks.
//  Revision: 1.0  initial release
// ============================================================================
module tb_meas_hold_filter;

  localparam int AVG = 2;
  localparam int N   = 4;
  localparam int REF = 500;
  localparam int TO  = 2000;

  logic        clk_1khz = 1'b0;
  logic        rst_n    = 1'b1;
  logic        raw_valid = 1'b0;
  logic [15:0] raw_fre  = '0;
  logic [11:0] raw_phas = '0;
  logic [15:0] fre;
  logic [11:0] phas;
  logic        upd;
  logic        stale;

  always #5 clk_1khz = ~clk_1khz;

  meas_hold_filter #(.AVG_LOG2(AVG), .REFRESH_MS(REF), .TIMEOUT_MS(TO)) dut (
    .clk_1khz  (clk_1khz),
    .rst_n     (rst_n),
    .raw_valid (raw_valid),
    .raw_fre   (raw_fre),
    .raw_phas  (raw_phas),
    .fre       (fre),
    .phas      (phas),
    .upd       (upd),
    .stale     (stale)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: outputs, pending block, sample lists, counters.
  logic [15:0] m_fre, m_pf;
  logic [11:0] m_phas, m_pp;
  logic        m_stale, m_upd, m_pvld;
  int          m_ref, m_idle;
  int          qf[$];
  int          qp[$];

  int    cyc_bad;
  int    dut_upds;
  string first_bad;

  task automatic model_reset();
    m_fre = '0; m_phas = '0; m_pf = '0; m_pp = '0;
    m_stale = 1'b1; m_upd = 1'b0; m_pvld = 1'b0;
    m_ref = 0; m_idle = 0;
    qf.delete(); qp.delete();
  endtask

  task automatic do_reset();
    raw_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_1khz);
    @(negedge clk_1khz);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle, advance the model by the same cycle, record mismatches.
  task automatic step(input logic v, input logic [15:0] f, input logic [11:0] p);
    bit tick, to;
    int sf, sp;
    raw_valid = v; raw_fre = f; raw_phas = p;
    @(posedge clk_1khz);
    tick  = (m_ref == REF - 1);
    to    = !v && (m_idle == TO - 1) && (!m_stale || m_pvld || qf.size() != 0);
    m_upd = 1'b0;
    if (to) begin
      m_upd = !m_stale;
      m_fre = '0; m_phas = '0; m_stale = 1'b1; m_pvld = 1'b0;
      qf.delete(); qp.delete();
    end else begin
      if (tick && m_pvld) begin
        m_fre = m_pf; m_phas = m_pp; m_stale = 1'b0; m_upd = 1'b1; m_pvld = 1'b0;
      end
      if (v) begin
        qf.push_back(int'(f));
        qp.push_back((p > 12'd999) ? 999 : int'(p));
        if (qf.size() == N) begin
          sf = 0; sp = 0;
          foreach (qf[i]) begin sf += qf[i]; sp += qp[i]; end
          m_pf = 16'(sf / N); m_pp = 12'(sp / N); m_pvld = 1'b1;
          qf.delete(); qp.delete();
        end
      end
    end
    m_ref  = (m_ref + 1) % REF;
    m_idle = v ? 0 : ((m_idle + 1 > TO - 1) ? TO - 1 : m_idle + 1);
    #1;
    if (fre !== m_fre || phas !== m_phas || stale !== m_stale || upd !== m_upd) begin
      if (cyc_bad == 0)
        first_bad = $sformatf("t=%0t fre=%0d/%0d phas=%0d/%0d stale=%b/%b upd=%b/%b",
                              $time, fre, m_fre, phas, m_phas, stale, m_stale, upd, m_upd);
      cyc_bad++;
    end
    if (upd === 1'b1) dut_upds++;
  endtask

  task automatic wait_upd(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      step(1'b0, '0, '0);
      if (upd === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    int u0;
    cyc_bad = 0;
    #2 rst_n = 1'b0;
    #3;
    n_checks++; if (fre !== 16'd0) begin n_errors++; $display("FAIL reset_fre got %0d exp 0", fre); end
    n_checks++; if (phas !== 12'd0) begin n_errors++; $display("FAIL reset_phas got %0d exp 0", phas); end
    n_checks++; if (stale !== 1'b1) begin n_errors++; $display("FAIL reset_stale got %b exp 1", stale); end
    n_checks++; if (upd !== 1'b0) begin n_errors++; $display("FAIL reset_upd got %b exp 0", upd); end
    repeat (2) @(posedge clk_1khz);
    @(negedge clk_1khz);
    rst_n = 1'b1;
    model_reset();
    u0 = dut_upds;
    repeat (3000) step(1'b0, '0, '0);
    n_checks++; if (dut_upds - u0 !== 0) begin n_errors++; $display("FAIL idle_upd_count got %0d exp 0", dut_upds - u0); end
    n_checks++; if (stale !== 1'b1 || fre !== 16'd0 || phas !== 12'd0) begin
      n_errors++; $display("FAIL idle_outputs got fre=%0d phas=%0d stale=%b exp 0 0 1", fre, phas, stale); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL reset_model got %0d bad cycles exp 0: %s", cyc_bad, first_bad); end
  endtask

  task automatic test_average();
    int u0; bit got;
    cyc_bad = 0;
    u0 = dut_upds;
    for (int i = 0; i < N; i++) step(1'b1, 16'(12000 + 4 * i), 12'(100 + i));
    wait_upd(REF + 10, got);
    n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL avg_upd_seen got %b exp 1", got); end
    n_checks++; if (fre !== 16'd12006) begin n_errors++; $display("FAIL avg_fre got %0d exp 12006", fre); end
    n_checks++; if (phas !== 12'd101) begin n_errors++; $display("FAIL avg_phas got %0d exp 101", phas); end
    n_checks++; if (stale !== 1'b0) begin n_errors++; $display("FAIL avg_stale got %b exp 0", stale); end
    n_checks++; if (dut_upds - u0 !== 1) begin n_errors++; $display("FAIL avg_upd_count got %0d exp 1", dut_upds - u0); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL avg_model got %0d bad cycles exp 0: %s", cyc_bad, first_bad); end
  endtask

  task automatic test_clamp();
    bit got;
    cyc_bad = 0;
    for (int i = 0; i < N; i++) step(1'b1, 16'hFFFF, 12'd1500);
    wait_upd(REF + 10, got);
    n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL clamp_upd_seen got %b exp 1", got); end
    n_checks++; if (fre !== 16'hFFFF) begin n_errors++; $display("FAIL clamp_fre got %0h exp ffff", fre); end
    n_checks++; if (phas !== 12'd999) begin n_errors++; $display("FAIL clamp_phas got %0d exp 999", phas); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL clamp_model got %0d bad cycles exp 0: %s", cyc_bad, first_bad); end
  endtask

  task automatic test_back_to_back();
    int u0, sf, sp; bit got;
    logic [15:0] f; logic [11:0] p;
    cyc_bad = 0;
    for (int i = 0; i < REF && m_ref != 0; i++) step(1'b0, '0, '0);
    u0 = dut_upds;
    sf = 0; sp = 0;
    for (int b = 0; b < 8; b++) begin
      sf = 0; sp = 0;
      for (int i = 0; i < N; i++) begin
        f = 16'($urandom); p = 12'($urandom_range(1200));
        sf += int'(f); sp += (p > 12'd999) ? 999 : int'(p);
        step(1'b1, f, p);
      end
    end
    wait_upd(REF + 10, got);
    n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL b2b_upd_seen got %b exp 1", got); end
    n_checks++; if (fre !== 16'(sf / N)) begin n_errors++; $display("FAIL b2b_fre got %0d exp %0d", fre, sf / N); end
    n_checks++; if (phas !== 12'(sp / N)) begin n_errors++; $display("FAIL b2b_phas got %0d exp %0d", phas, sp / N); end
    repeat (REF + 20) step(1'b0, '0, '0);
    n_checks++; if (dut_upds - u0 !== 1) begin n_errors++; $display("FAIL b2b_upd_count got %0d exp 1", dut_upds - u0); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL b2b_model got %0d bad cycles exp 0: %s", cyc_bad, first_bad); end
  endtask

  task automatic test_timeout();
    int u0, sf, sp; bit got;
    logic [15:0] f; logic [11:0] p;
    cyc_bad = 0;
    for (int i = 0; i < N; i++) step(1'b1, 16'($urandom_range(60000, 1000)), 12'($urandom_range(999, 1)));
    u0 = dut_upds;
    repeat (TO - 10) step(1'b0, '0, '0);
    n_checks++; if (stale !== 1'b0) begin n_errors++; $display("FAIL to_not_yet got stale=%b exp 0", stale); end
    n_checks++; if (dut_upds - u0 !== 1) begin n_errors++; $display("FAIL to_refresh_upd got %0d exp 1", dut_upds - u0); end
    repeat (30) step(1'b0, '0, '0);
    n_checks++; if (stale !== 1'b1 || fre !== 16'd0 || phas !== 12'd0) begin
      n_errors++; $display("FAIL to_cleared got fre=%0d phas=%0d stale=%b exp 0 0 1", fre, phas, stale); end
    n_checks++; if (dut_upds - u0 !== 2) begin n_errors++; $display("FAIL to_upd_once got %0d exp 2", dut_upds - u0); end
    repeat (REF + 20) step(1'b0, '0, '0);
    n_checks++; if (dut_upds - u0 !== 2) begin n_errors++; $display("FAIL to_no_repeat got %0d exp 2", dut_upds - u0); end
    sf = 0; sp = 0;
    for (int i = 0; i < N; i++) begin
      f = 16'($urandom); p = 12'($urandom_range(999));
      sf += int'(f); sp += int'(p);
      step(1'b1, f, p);
    end
    wait_upd(REF + 10, got);
    n_checks++; if (got !== 1'b1 || stale !== 1'b0) begin n_errors++; $display("FAIL to_resume got upd_seen=%b stale=%b exp 1 0", got, stale); end
    n_checks++; if (fre !== 16'(sf / N) || phas !== 12'(sp / N)) begin
      n_errors++; $display("FAIL to_resume_val got %0d/%0d exp %0d/%0d", fre, phas, sf / N, sp / N); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL to_model got %0d bad cycles exp 0: %s", cyc_bad, first_bad); end
  endtask

  task automatic test_reset_midblock();
    int u0, sf, sp; bit got;
    logic [15:0] f; logic [11:0] p;
    for (int i = 0; i < N - 1; i++) step(1'b1, 16'd500, 12'd50);
    do_reset();
    cyc_bad = 0;
    u0 = dut_upds;
    f = 16'($urandom); p = 12'($urandom_range(999));
    sf = int'(f); sp = int'(p);
    step(1'b1, f, p);
    repeat (REF + 100) step(1'b0, '0, '0);
    n_checks++; if (dut_upds - u0 !== 0 || stale !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid_noupd got upds=%0d stale=%b exp 0 1", dut_upds - u0, stale); end
    for (int i = 0; i < N - 1; i++) begin
      f = 16'($urandom); p = 12'($urandom_range(999));
      sf += int'(f); sp += int'(p);
      step(1'b1, f, p);
    end
    wait_upd(REF + 10, got);
    n_checks++; if (got !== 1'b1 || fre !== 16'(sf / N) || phas !== 12'(sp / N)) begin
      n_errors++; $display("FAIL rst_mid_upd got seen=%b %0d/%0d exp 1 %0d/%0d", got, fre, phas, sf / N, sp / N); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL rst_mid_model got %0d bad cycles exp 0: %s", cyc_bad, first_bad); end
  endtask

  task automatic test_random();
    cyc_bad = 0;
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(2) == 0), 16'($urandom), 12'($urandom_range(4095)));
    repeat (TO + 50) step(1'b0, '0, '0);
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(4) == 0), 16'($urandom), 12'($urandom_range(1100)));
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL random_model got %0d bad cycles exp 0: %s", cyc_bad, first_bad); end
  endtask

  initial begin
    dut_upds = 0;
    model_reset();
    test_reset();
    test_average();
    test_clamp();
    test_back_to_back();
    test_timeout();
    test_reset_midblock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_meas_hold_filter
`default_nettype wire
